// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter: shares the register-file write port between two
// writeback requesters; r0 writes are accepted and discarded.  Rev 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          grant_id,
  output logic [7:0]    drop_cnt
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic          last_grant_q, last_grant_d;
  logic [3:0]    wait_cnt_q,   wait_cnt_d;
  logic          rf_we_q,      rf_we_d;
  logic [AW-1:0] rf_waddr_q,   rf_waddr_d;
  logic [DW-1:0] rf_wdata_q,   rf_wdata_d;
  logic          grant_id_q,   grant_id_d;
  logic [7:0]    drop_cnt_q,   drop_cnt_d;

  logic          sel;
  logic          accept;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;

  // Selection looks only at valids and registered state so ready never
  // depends on address or data.
  always_comb begin
    sel = 1'b0;
    if (PRIO_MODE == 0) begin
      if (req0_valid && req1_valid) sel = ~last_grant_q;
      else                          sel = req1_valid;
    end else begin
      if (req1_valid && (wait_cnt_q == MAX_WAIT_C)) sel = 1'b1;
      else if (req0_valid)                          sel = 1'b0;
      else                                          sel = req1_valid;
    end
  end

  assign req0_ready = rst_n & req0_valid & ~sel;
  assign req1_ready = rst_n & req1_valid &  sel;
  assign accept     = req0_ready | req1_ready;
  assign acc_addr   = sel ? req1_addr : req0_addr;
  assign acc_data   = sel ? req1_data : req0_data;

  always_comb begin
    last_grant_d = last_grant_q;
    wait_cnt_d   = 4'd0;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    grant_id_d   = grant_id_q;
    drop_cnt_d   = drop_cnt_q;

    if ((PRIO_MODE != 0) && req1_valid && !req1_ready)
      wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;

    if (accept) begin
      last_grant_d = sel;
      grant_id_d   = sel;
      rf_waddr_d   = acc_addr;
      rf_wdata_d   = acc_data;
      rf_we_d      = (acc_addr != '0);
      if ((acc_addr == '0) && (drop_cnt_q != 8'hFF))
        drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      wait_cnt_q   <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      grant_id_q   <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      grant_id_q   <= grant_id_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_id = grant_id_q;
  assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter: directed bench with a round-robin and a
// fixed-priority instance plus a small register-file model.  Rev 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rr_v0 = 0, rr_v1 = 0;
  logic [4:0]  rr_a0 = 0, rr_a1 = 0;
  logic [31:0] rr_d0 = 0, rr_d1 = 0;
  logic        rr_r0, rr_r1, rr_we, rr_gid;
  logic [4:0]  rr_waddr;
  logic [31:0] rr_wdata;
  logic [7:0]  rr_drop;

  logic        fx_v0 = 0, fx_v1 = 0;
  logic [4:0]  fx_a0 = 0, fx_a1 = 0;
  logic [31:0] fx_d0 = 0, fx_d1 = 0;
  logic        fx_r0, fx_r1, fx_we, fx_gid;
  logic [4:0]  fx_waddr;
  logic [31:0] fx_wdata;
  logic [7:0]  fx_drop;

  regfile_wb_arbiter #(.AW(5), .DW(32), .PRIO_MODE(0), .MAX_WAIT(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rr_v0), .req0_addr(rr_a0), .req0_data(rr_d0), .req0_ready(rr_r0),
    .req1_valid(rr_v1), .req1_addr(rr_a1), .req1_data(rr_d1), .req1_ready(rr_r1),
    .rf_we(rr_we), .rf_waddr(rr_waddr), .rf_wdata(rr_wdata),
    .grant_id(rr_gid), .drop_cnt(rr_drop));

  regfile_wb_arbiter #(.AW(5), .DW(32), .PRIO_MODE(1), .MAX_WAIT(4)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fx_v0), .req0_addr(fx_a0), .req0_data(fx_d0), .req0_ready(fx_r0),
    .req1_valid(fx_v1), .req1_addr(fx_a1), .req1_data(fx_d1), .req1_ready(fx_r1),
    .rf_we(fx_we), .rf_waddr(fx_waddr), .rf_wdata(fx_wdata),
    .grant_id(fx_gid), .drop_cnt(fx_drop));

  // Register-file model fed by the round-robin instance.
  logic [31:0] model_rf [32];
  int          wr_cnt = 0;
  int          r0_writes = 0;
  always @(posedge clk) begin
    if (rr_we) begin
      model_rf[rr_waddr] <= rr_wdata;
      wr_cnt <= wr_cnt + 1;
      if (rr_waddr == 5'd0) r0_writes <= r0_writes + 1;
    end
    if (fx_we && fx_waddr == 5'd0) r0_writes <= r0_writes + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rr_v0 = 0; rr_v1 = 0; fx_v0 = 0; fx_v1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rr_v0 = 1; rr_v1 = 1;
    #1;
    checks++;
    if (rr_r0 !== 1'b0 || rr_r1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", rr_r0, rr_r1);
    end
    rr_v0 = 0; rr_v1 = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rr_we !== 0 || rr_waddr !== 0 || rr_wdata !== 0 || rr_gid !== 0 || rr_drop !== 0) begin
      errors++;
      $display("FAIL reset_rr got we=%b a=%0d d=%h g=%b drop=%0d want all 0",
               rr_we, rr_waddr, rr_wdata, rr_gid, rr_drop);
    end
    checks++;
    if (fx_we !== 0 || fx_drop !== 0) begin
      errors++; $display("FAIL reset_fx got we=%b drop=%0d want 0 0", fx_we, fx_drop);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    rr_v0 = 1; rr_a0 = 5'd5; rr_d0 = 32'hDEADBEEF;
    #1;
    checks++;
    if (rr_r0 !== 1'b1 || rr_r1 !== 1'b0) begin
      errors++; $display("FAIL single_ready got %b%b want 10", rr_r0, rr_r1);
    end
    @(negedge clk);
    rr_v0 = 0;
    checks++;
    if (rr_we !== 1 || rr_waddr !== 5'd5 || rr_wdata !== 32'hDEADBEEF || rr_gid !== 0) begin
      errors++;
      $display("FAIL single_out got we=%b a=%0d d=%h g=%b want 1 5 deadbeef 0",
               rr_we, rr_waddr, rr_wdata, rr_gid);
    end
    @(negedge clk);
    checks++;
    if (rr_we !== 1'b0) begin
      errors++; $display("FAIL single_idle got we=%b want 0", rr_we);
    end
  endtask

  task automatic test_rr_contention();
    logic [4:0] exp_addr [4];
    logic       exp_g    [4];
    int i0, i1;
    exp_addr[0] = 5'd1; exp_addr[1] = 5'd9; exp_addr[2] = 5'd2; exp_addr[3] = 5'd10;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
    do_reset();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (rr_we !== 1 || rr_waddr !== exp_addr[k-1] || rr_gid !== exp_g[k-1]) begin
          errors++;
          $display("FAIL rr_seq[%0d] got we=%b a=%0d g=%b want 1 %0d %b",
                   k-1, rr_we, rr_waddr, rr_gid, exp_addr[k-1], exp_g[k-1]);
        end
      end
      if (k < 4) begin
        rr_v0 = 1; rr_a0 = 5'(1 + i0); rr_d0 = 32'(100 + i0);
        rr_v1 = 1; rr_a1 = 5'(9 + i1); rr_d1 = 32'(200 + i1);
        #1;
        if (rr_r0) i0++;
        if (rr_r1) i1++;
      end else begin
        rr_v0 = 0; rr_v1 = 0;
      end
    end
  endtask

  task automatic test_r0_drop();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (rr_we !== 1'b0) begin
          errors++; $display("FAIL drop_we[%0d] got %b want 0", k, rr_we);
        end
      end
      if (k < 3) begin
        rr_v1 = 1; rr_a1 = 5'd0; rr_d1 = 32'h1234;
        #1;
        checks++;
        if (rr_r1 !== 1'b1) begin
          errors++; $display("FAIL drop_ready[%0d] got %b want 1", k, rr_r1);
        end
      end else rr_v1 = 0;
    end
    checks++;
    if (rr_drop !== 8'd3) begin
      errors++; $display("FAIL drop_cnt got %0d want 3", rr_drop);
    end
  endtask

  task automatic test_fixed_starvation();
    logic expg;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k > 0) begin
        expg = ((k - 1) % 5 == 4);
        checks++;
        if (fx_gid !== expg || fx_we !== 1'b1) begin
          errors++; $display("FAIL fx_gid[%0d] got %b we=%b want %b 1", k-1, fx_gid, fx_we, expg);
        end
      end
      if (k < 10) begin
        fx_v0 = 1; fx_a0 = 5'd2; fx_d0 = 32'(k);
        fx_v1 = 1; fx_a1 = 5'd3; fx_d1 = 32'(k + 50);
        #1;
        expg = (k % 5 == 4);
        checks++;
        if (fx_r1 !== expg || fx_r0 !== !expg) begin
          errors++; $display("FAIL fx_ready[%0d] got %b%b want %b%b", k, fx_r0, fx_r1, !expg, expg);
        end
      end else begin
        fx_v0 = 0; fx_v1 = 0;
      end
    end
  endtask

  task automatic test_drop_saturate();
    repeat (255) begin
      @(negedge clk);
      fx_v0 = 1; fx_a0 = 5'd0; fx_d0 = 32'h55;
    end
    @(negedge clk);
    checks++;
    if (fx_drop !== 8'd255) begin
      errors++; $display("FAIL drop_sat255 got %0d want 255", fx_drop);
    end
    @(negedge clk);
    fx_v0 = 0;
    checks++;
    if (fx_drop !== 8'd255) begin
      errors++; $display("FAIL drop_sat_hold got %0d want 255", fx_drop);
    end
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk);
    rr_v0 = 1; rr_a0 = 5'd7; rr_d0 = 32'hA;
    rr_v1 = 1; rr_a1 = 5'd7; rr_d1 = 32'hB;
    #1;
    checks++;
    if (rr_r0 !== 1'b1 || rr_r1 !== 1'b0) begin
      errors++; $display("FAIL coll_ready0 got %b%b want 10", rr_r0, rr_r1);
    end
    @(negedge clk);
    rr_v0 = 0;
    checks++;
    if (rr_we !== 1 || rr_waddr !== 5'd7 || rr_wdata !== 32'hA) begin
      errors++; $display("FAIL coll_first got we=%b a=%0d d=%h want 1 7 a", rr_we, rr_waddr, rr_wdata);
    end
    @(negedge clk);
    rr_v1 = 0;
    checks++;
    if (rr_we !== 1 || rr_wdata !== 32'hB || rr_gid !== 1'b1) begin
      errors++; $display("FAIL coll_second got we=%b d=%h g=%b want 1 b 1", rr_we, rr_wdata, rr_gid);
    end
    @(negedge clk);
    checks++;
    if (model_rf[7] !== 32'hB) begin
      errors++; $display("FAIL coll_final got %h want b", model_rf[7]);
    end
  endtask

  task automatic test_async_reset();
    int wr_before;
    @(negedge clk);
    rr_v0 = 1; rr_a0 = 5'd3; rr_d0 = 32'h3333;
    @(negedge clk);
    checks++;
    if (rr_we !== 1'b1) begin
      errors++; $display("FAIL areset_pre got we=%b want 1", rr_we);
    end
    wr_before = wr_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rr_we !== 1'b0 || rr_r0 !== 1'b0 || rr_drop !== 8'd0) begin
      errors++; $display("FAIL areset_now got we=%b ready=%b drop=%0d want 0 0 0", rr_we, rr_r0, rr_drop);
    end
    @(negedge clk);
    checks++;
    if (wr_cnt !== wr_before) begin
      errors++; $display("FAIL areset_nowrite got %0d writes want %0d", wr_cnt, wr_before);
    end
    rst_n = 1'b1;
    rr_v0 = 1; rr_a0 = 5'd4; rr_v1 = 1; rr_a1 = 5'd8;
    #1;
    checks++;
    if (rr_r0 !== 1'b1 || rr_r1 !== 1'b0) begin
      errors++; $display("FAIL areset_tie got %b%b want 10", rr_r0, rr_r1);
    end
    @(negedge clk);
    rr_v0 = 0; rr_v1 = 0;
  endtask

  task automatic test_no_r0_write();
    checks++;
    if (r0_writes !== 0) begin
      errors++; $display("FAIL r0_written got %0d want 0", r0_writes);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_contention();
    test_r0_drop();
    test_fixed_starvation();
    test_drop_saturate();
    test_collision();
    test_async_reset();
    test_no_r0_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
